ubit2bin_bi: RTL and testbench

Bipolar unary-to-binary decoder. It consumes a bipolar bitstream from the uMUL_bi multiplier output or any Sobol-encoded stream, and counts ones over a fixed window of 2^BITWIDTH valid samples. At the end of each window it presents the recovered value in offset-binary and two's-complement form. It sits at the output end of the unary datapath and returns results to the binary domain, with a valid/ready handshake toward the consumer.

---
 rtl/ubit2bin_bi_pkg.sv | 25 ++
 rtl/ubit2bin_bi_ucnt_en.sv | 22 ++
 rtl/ubit2bin_bi.sv | 118 +++++++++++
 tb/tb_ubit2bin_bi.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ubit2bin_bi_pkg.sv
// ubit2bin_bi shared definitions: state encoding and window length.
`ifndef UBIT2BIN_BI_PKG_SV
`define UBIT2BIN_BI_PKG_SV

`define UB_WIN_LEN(bw) (1 << (bw))

package ubit2bin_bi_pkg;

    localparam logic [1:0] UB_IDLE  = 2'd0;
    localparam logic [1:0] UB_ACCUM = 2'd1;
    localparam logic [1:0] UB_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = UB_IDLE,
        S_ACCUM = UB_ACCUM,
        S_HOLD  = UB_HOLD
    } ub_state_t;

    function automatic int win_len(input int bw);
        return `UB_WIN_LEN(bw);
    endfunction

endpackage

`endif

// File: rtl/ubit2bin_bi_ucnt_en.sv
// Up-counter with synchronous clear (priority) and enable.
module ucnt_en #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ubit2bin_bi.sv
// Bipolar unary-to-binary decoder: counts ones over 2^BITWIDTH samples
// and presents the result with a valid/ready handshake.
import ubit2bin_bi_pkg::*;

module ubit2bin_bi #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic                iStart,
    input  logic                iEn,
    input  logic                iBit,
    input  logic                iReady,
    output logic                oBusy,
    output logic                oValid,
    output logic [BITWIDTH-1:0] oBin,
    output logic [BITWIDTH-1:0] oSigned
);

    localparam int CW = BITWIDTH + 1;
    localparam logic [CW-1:0] WIN  = CW'(win_len(BITWIDTH));
    localparam logic [CW-1:0] LAST = WIN - CW'(1);
    localparam logic [BITWIDTH-1:0] SAT = {BITWIDTH{1'b1}};

    ub_state_t state_q;
    ub_state_t state_d;

    logic [CW-1:0]       smp_cnt;
    logic [CW-1:0]       one_cnt;
    logic [CW-1:0]       ones_next;
    logic [BITWIDTH-1:0] bin_q;
    logic [BITWIDTH-1:0] bin_d;
    logic                cnt_clr;
    logic                smp_en;
    logic                one_en;
    logic                last;
    logic                valid_q;
    logic                busy_q;

    assign smp_en    = (state_q == S_ACCUM) & iEn;
    assign one_en    = smp_en & iBit;
    assign ones_next = one_cnt + CW'(iBit);
    assign last      = smp_en & (smp_cnt == LAST);

    ucnt_en #(.W(CW)) u_smp_cnt (
        .clk   (iClk),
        .rst_n (iRstN),
        .clr   (cnt_clr),
        .en    (smp_en),
        .cnt   (smp_cnt)
    );

    ucnt_en #(.W(CW)) u_one_cnt (
        .clk   (iClk),
        .rst_n (iRstN),
        .clr   (cnt_clr),
        .en    (one_en),
        .cnt   (one_cnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        bin_d   = bin_q;
        unique case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_ACCUM;
                    cnt_clr = 1'b1;
                end
            end
            S_ACCUM: begin
                if (last) begin
                    state_d = S_HOLD;
                    bin_d   = (ones_next == WIN) ? SAT
                                                 : ones_next[BITWIDTH-1:0];
                end
            end
            S_HOLD: begin
                if (valid_q && iReady) begin
                    state_d = iStart ? S_ACCUM : S_IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
        // Clear overrides everything but leaves the last result visible
        if (iClr) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
            bin_d   = bin_q;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            valid_q <= (state_d == S_HOLD);
            busy_q  <= (state_d == S_ACCUM);
        end
    end

    assign oBusy   = busy_q;
    assign oValid  = valid_q;
    assign oBin    = bin_q;
    assign oSigned = {~bin_q[BITWIDTH-1], bin_q[BITWIDTH-2:0]};

endmodule

// File: tb/tb_ubit2bin_bi.sv
// Scoreboard bench for ubit2bin_bi with BITWIDTH=4 (N=16).
module tb_ubit2bin_bi;

    localparam int BW = 4;
    localparam int N  = 16;

    logic iClk   = 1'b0;
    logic iRstN  = 1'b0;
    logic iClr   = 1'b0;
    logic iStart = 1'b0;
    logic iEn    = 1'b0;
    logic iBit   = 1'b0;
    logic iReady = 1'b0;
    logic oBusy;
    logic oValid;
    logic [BW-1:0] oBin;
    logic [BW-1:0] oSigned;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_res = 0;

    typedef struct {
        int bin;
        int at;
    } exp_t;

    exp_t sbq[$];

    ubit2bin_bi #(.BITWIDTH(BW)) dut (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .iClr    (iClr),
        .iStart  (iStart),
        .iEn     (iEn),
        .iBit    (iBit),
        .iReady  (iReady),
        .oBusy   (oBusy),
        .oValid  (oValid),
        .oBin    (oBin),
        .oSigned (oSigned)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor: every rising oValid must match the oldest expected result
    logic prev_v = 1'b0;
    always @(negedge iClk) begin
        exp_t e;
        if (oValid && !prev_v) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got oBin=%0d with no result pending",
                         oBin);
            end else begin
                e = sbq.pop_front();
                chk("mon_bin", int'(oBin), e.bin);
                chk("mon_signed", int'($signed(oSigned)), e.bin - N / 2);
                chk("mon_latency", cyc, e.at);
            end
        end
        prev_v = oValid;
    end

    function automatic int sat(input int ones);
        return (ones >= N) ? N - 1 : ones;
    endfunction

    // 0 random, 1 all ones, 2 all zeros, 3 alternating, 4 first six ones
    function automatic logic pick(input int mode, input int idx);
        case (mode)
            1: return 1'b1;
            2: return 1'b0;
            3: return (idx % 2) == 0;
            4: return idx < 6;
            default: return 1'($urandom_range(1));
        endcase
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic start_win();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    // gap_pct < 0 selects the fixed enable pattern 1,0,0,1,0,0,...
    task automatic feed(input int n, input int mode, input int gap_pct,
                        input bit push, output int ones);
        int got;
        int k;
        got  = 0;
        k    = 0;
        ones = 0;
        while (got < n) begin
            chk("busy_in_window", int'(oBusy), 1);
            if (gap_pct < 0) iEn = (k % 3) == 0;
            else iEn = $urandom_range(99) >= gap_pct;
            iStart = $urandom_range(3) == 0;
            if (iEn) begin
                iBit = pick(mode, got);
                ones += int'(iBit);
                got++;
                if (got == n && push) begin
                    sbq.push_back('{bin: sat(ones), at: cyc + 1});
                    last_res = sat(ones);
                end
            end else begin
                iBit = 1'($urandom_range(1));
            end
            tick();
            k++;
        end
        iEn    = 1'b0;
        iBit   = 1'b0;
        iStart = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!oValid && k < 8) begin
            tick();
            k++;
        end
        chk("valid_timeout", int'(oValid), 1);
    endtask

    task automatic junk_in_hold(input int n);
        for (int i = 0; i < n; i++) begin
            iEn  = 1'b1;
            iBit = 1'b1;
            tick();
            chk("hold_valid", int'(oValid), 1);
            chk("hold_bin", int'(oBin), last_res);
        end
        iEn  = 1'b0;
        iBit = 1'b0;
    endtask

    task automatic handshake(input bit st);
        iReady = 1'b1;
        iStart = st;
        tick();
        iReady = 1'b0;
        iStart = 1'b0;
        chk("busy_after_hs", int'(oBusy), int'(st));
        chk("valid_after_hs", int'(oValid), 0);
    endtask

    initial begin
        int ones;
        bit chained;

        #12;
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_bin", int'(oBin), 0);
        chk("rst_signed", int'($signed(oSigned)), -N / 2);
        iRstN = 1'b1;
        tick();

        // all ones saturates; result held while consumer stalls
        start_win();
        feed(N, 1, 0, 1'b1, ones);
        wait_valid();
        junk_in_hold(10);
        handshake(1'b0);

        // zeros, then back-to-back alternating window after junk in HOLD
        start_win();
        feed(N, 2, 0, 1'b1, ones);
        wait_valid();
        junk_in_hold(3);
        handshake(1'b1);
        feed(N, 3, 0, 1'b1, ones);
        wait_valid();
        handshake(1'b0);

        // sparse enables, ones only on first six accepted samples
        start_win();
        feed(N, 4, -1, 1'b1, ones);
        wait_valid();
        handshake(1'b0);

        // clear mid-window keeps the previous result
        start_win();
        feed(9, 0, 20, 1'b0, ones);
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        chk("clr_busy", int'(oBusy), 0);
        chk("clr_valid", int'(oValid), 0);
        chk("clr_bin", int'(oBin), last_res);
        chk("clr_signed", int'($signed(oSigned)), last_res - N / 2);
        start_win();
        feed(N, 0, 30, 1'b1, ones);
        wait_valid();

        // clear in HOLD discards the pending result
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        chk("clr_hold_valid", int'(oValid), 0);
        chk("clr_hold_bin", int'(oBin), last_res);

        // asynchronous reset mid-window
        start_win();
        feed(5, 1, 0, 1'b0, ones);
        #2;
        iRstN = 1'b0;
        #1;
        chk("arst_busy", int'(oBusy), 0);
        chk("arst_valid", int'(oValid), 0);
        chk("arst_bin", int'(oBin), 0);
        chk("arst_signed", int'($signed(oSigned)), -N / 2);
        #1;
        iRstN = 1'b1;
        tick();
        last_res = 0;

        // randomized windows with random gaps and handshake styles
        chained = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (!chained) start_win();
            feed(N, 0, $urandom_range(60), 1'b1, ones);
            wait_valid();
            junk_in_hold($urandom_range(3));
            chained = 1'($urandom_range(1));
            handshake(chained);
        end
        if (chained) begin
            iClr = 1'b1;
            tick();
            iClr = 1'b0;
        end

        repeat (3) tick();
        chk("queue_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
